// File: rtl/enc_input_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_input_key_pkg
// Description : Shared types and constants for the input-key frame encoder.
//               Holds the frame FSM state encoding, the 4-symbol preamble
//               pattern and the count of fixed symbols in a frame.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_input_key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE1 = 3'd1,
        ST_PRE2 = 3'd2,
        ST_PRE3 = 3'd3,
        ST_PRE4 = 3'd4,
        ST_MODE = 3'd5,
        ST_HOLD = 3'd6,
        ST_GAP  = 3'd7
    } state_t;

    // Preamble symbols, sent MSB first (PRE1 carries bit 3).
    localparam logic [3:0] PREAMBLE = 4'b1010;

    // Preamble plus the first mode symbol: minimum valid-symbol run of a frame.
    localparam int unsigned SYM_COUNT = 5;

    // Key symbol carried by a preamble state; 0 for any other state.
    function automatic logic preamble_bit(input state_t s);
        logic b;
        b = 1'b0;
        case (s)
            ST_PRE1: b = PREAMBLE[3];
            ST_PRE2: b = PREAMBLE[2];
            ST_PRE3: b = PREAMBLE[1];
            ST_PRE4: b = PREAMBLE[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module      : key_hold_cnt
// Description : Loadable down-counter with a zero flag. Counts down only
//               while dec is asserted and never wraps below zero.
// Ports       : clk      - clock (rising edge)
//               rst_n    - asynchronous active-low reset, clears the count
//               load     - load load_val (has priority over dec)
//               load_val - value to load
//               dec      - decrement request
//               zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module key_hold_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    assign zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && !zero) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/enc_input_key.sv
`default_nettype none
// ============================================================================
// Module      : enc_input_key
// Description : Serial key-frame encoder. On Start it emits a preamble
//               (1,0,1,0), one mode symbol plus HoldLen repeats of it, then
//               a one-cycle gap carrying the Done pulse. Abort cuts a frame
//               short straight into the gap.
// Ports       : Clk      - clock (rising edge)
//               Reset    - asynchronous active-low reset
//               Start    - frame request, sampled only in IDLE
//               ModeIn   - mode to encode, latched on accepted Start
//               HoldLen  - extra mode-symbol cycles, latched on accepted Start
//               Abort    - terminate an in-progress frame
//               InputKey - registered serial key symbol
//               ValidCmd - registered symbol-valid qualifier
//               Busy     - frame in progress (all states except IDLE)
//               Done     - one-cycle pulse in the gap cycle
// Revision    : 1.0 - initial release
// ============================================================================
module enc_input_key
    import enc_input_key_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             ModeIn,
    input  logic [LEN_W-1:0] HoldLen,
    input  logic             Abort,
    output logic             InputKey,
    output logic             ValidCmd,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q;
    state_t           state_d;
    logic             mode_q;
    logic             mode_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    logic             key_q;
    logic             key_d;
    logic             valid_q;
    logic             valid_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             cnt_load;
    logic [LEN_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    // HOLD runs len_q cycles: the counter is loaded with len_q-1 and HOLD
    // exits on the cycle the counter reads zero, so the full 2^LEN_W-1
    // range fits without wrapping.
    key_hold_cnt #(
        .LEN_W (LEN_W)
    ) u_hold_cnt (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // ------------------------------------------------------------------
    // State and latched-parameter registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_PRE1;
                    mode_d  = ModeIn;
                    len_d   = HoldLen;
                end
            end
            ST_PRE1: state_d = ST_PRE2;
            ST_PRE2: state_d = ST_PRE3;
            ST_PRE3: state_d = ST_PRE4;
            ST_PRE4: state_d = ST_MODE;
            ST_MODE: begin
                if (len_q != '0) begin
                    state_d      = ST_HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = len_q - LEN_W'(1);
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort beats every other transition while symbols are being sent.
        if (Abort && (state_q != ST_IDLE) && (state_q != ST_GAP)) begin
            state_d  = ST_GAP;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Decoding the next state and registering it gives
    // output flops that always match the current state, with no input
    // reaching an output without passing through a flop.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = 1'b0;
        key_d   = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_GAP);
        case (state_d)
            ST_PRE1, ST_PRE2, ST_PRE3, ST_PRE4: begin
                valid_d = 1'b1;
                key_d   = preamble_bit(state_d);
            end
            ST_MODE, ST_HOLD: begin
                valid_d = 1'b1;
                key_d   = mode_d;
            end
            default: begin
                valid_d = 1'b0;
                key_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            key_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign InputKey = key_q;
    assign ValidCmd = valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
`default_nettype wire

// File: doc/enc_input_key.md
ENC_INPUT_KEY -- requirements
Module: enc_input_key

Interface
REQ-001 Parameter LEN_W, default 8, SHALL set the width of the hold-length input and internal hold counter.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Start  input  1  SHALL be the frame request, sampled only in IDLE.
REQ-005 ModeIn  input  1  SHALL be the mode to encode (0 -> decoder Mode 0, 1 -> decoder Mode 1), latched on accepted Start.
REQ-006 HoldLen  input  LEN_W  SHALL be the number of extra mode-symbol cycles after the first, latched on accepted Start.
REQ-007 Abort  input  1  SHALL be the request to terminate an in-progress frame.
REQ-008 InputKey  output  1  SHALL be the registered serial key symbol to the decoder.
REQ-009 ValidCmd  output  1  SHALL be the registered symbol-valid qualifier to the decoder.
REQ-010 Busy  output  1  SHALL be high while a frame (including its gap cycle) is in progress.
REQ-011 Done  output  1  SHALL be a one-cycle pulse marking frame end (normal or aborted).

Function
REQ-012 The FSM SHALL have states IDLE, PRE1, PRE2, PRE3, PRE4, MODE, HOLD, GAP.
REQ-013 Symbols per state (ValidCmd/InputKey) SHALL be: IDLE 0/0, PRE1 1/1, PRE2 1/0, PRE3 1/1, PRE4 1/0, MODE 1/ModeLatched, HOLD 1/ModeLatched, GAP 0/0.
REQ-014 All outputs SHALL be registered, decoded from current state only; no combinational input-to-output path.
REQ-015 Start=1 in IDLE at edge t SHALL latch ModeIn/HoldLen and enter PRE1, so ValidCmd=1, InputKey=1 is visible after edge t.
REQ-016 Start while not in IDLE SHALL be ignored, with no effect on latched mode/length.
REQ-017 Transitions SHALL be PRE1->PRE2->PRE3->PRE4->MODE, one cycle each.
REQ-018 MODE SHALL go to HOLD when latched HoldLen>0, else directly to GAP.
REQ-019 HOLD SHALL persist exactly HoldLen cycles via a down-counter loaded on entry, then go to GAP.
REQ-020 A normal frame SHALL therefore hold ValidCmd=1 for exactly 5+HoldLen consecutive cycles.
REQ-021 HoldLen = 2^LEN_W-1 SHALL be supported without counter wrap or early exit.
REQ-022 GAP SHALL last exactly one cycle, then return to IDLE; Done=1 only during GAP.
REQ-023 Start asserted in the GAP cycle SHALL be ignored; the next frame starts no earlier than the cycle after IDLE is re-entered.
REQ-024 Busy SHALL be 1 in every state except IDLE.
REQ-025 Abort=1 in any PRE*, MODE or HOLD state SHALL force GAP on the next edge, overriding all other transitions.
REQ-026 Abort in IDLE or GAP SHALL be ignored; Abort and Start together in IDLE SHALL start a frame.

Reset
REQ-027 Reset low SHALL immediately force IDLE, InputKey=0, ValidCmd=0, Busy=0, Done=0, counter=0, and latched mode/length=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no Done pulse.
REQ-029 After Reset is released, the first Start SHALL be honoured at the first rising edge.

Structure
REQ-030 Package enc_input_key_pkg SHALL hold the state enum, the preamble constant 4'b1010, and the symbol-count constant 5.
REQ-031 The design SHALL contain one sub-module, key_hold_cnt: a loadable LEN_W down-counter with a zero flag.

Verification
REQ-032 Reset low mid-HOLD -> all outputs 0 asynchronously; after release, Start works at the first edge.
REQ-033 Start, ModeIn=0, HoldLen=0 -> ValidCmd/InputKey = 1/1,1/0,1/1,1/0,1/0, then GAP 0/0 with Done=1; decoder Active=1, Mode=0 for one cycle.
REQ-034 Start, ModeIn=1, HoldLen=3 -> 8 ValidCmd cycles, keys 1,0,1,0,1,1,1,1; decoder Active=1, Mode=1 for 4 cycles.
REQ-035 Abort in PRE3 -> next cycle GAP, ValidCmd=0, Done=1; decoder never reaches Active.
REQ-036 Start held high through a frame with HoldLen=2 -> no second frame until IDLE is re-entered; second frame starts one cycle after the first GAP.
REQ-037 HoldLen=255 (LEN_W=8) -> exactly 260 ValidCmd cycles, then one GAP cycle.
